mem_sram_bridge: RTL
====================

// Module: mem_sram_bridge
// PURPOSE
//  Consumes the flat req/gnt memory port produced by the Ariane AXI-to-mem top level and backs it with on-chip SRAM.
//  Supplies grant, 1-cycle read data with an explicit valid, address range checking and access counters.
//  Sits directly downstream of the core+axi2mem wrapper in the fuzzing/taint testbench SoC.
// PARAMETERS
//  NUM_WORDS   1024                  SRAM depth in DATA_WIDTH words (power of 2, >=2)
//  ADDR_WIDTH  64                    request address width
//  DATA_WIDTH  64                    data width; STRB = DATA_WIDTH/8
//  BASE_ADDR   64'h8000_0000         byte address of word 0
//  ERR_DATA    64'hDEAD_BEEF_DEAD_BEEF  read data returned for out-of-range reads
//  CNT_WIDTH   32                    width of access/error counters
// PORTS
//  clk_i        in   1           clock
//  rst_ni       in   1           synchronous active-low reset
//  req_i        in   1           request valid
//  gnt_o        out  1           request accepted this cycle (req_i & gnt_o = handshake)
//  we_i         in   1           1=write, 0=read
//  addr_i       in   ADDR_WIDTH  byte address
//  strb_i       in   STRB        byte enables (writes only)
//  wdata_i      in   DATA_WIDTH  write data
//  rvalid_o     out  1           response valid (reads and writes), 1 cycle after handshake
//  rdata_o      out  DATA_WIDTH  read data, valid with rvalid_o on reads
//  err_o        out  1           with rvalid_o: access was out of range
//  rd_cnt_o     out  CNT_WIDTH   accepted in-range reads
//  wr_cnt_o     out  CNT_WIDTH   accepted in-range writes
//  err_cnt_o    out  CNT_WIDTH   accepted out-of-range accesses
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low.
//  Reset (rst_ni=0 at posedge): rvalid_o=0, err_o=0, rdata_o=0, all counters=0, LFSR=16'hACE1; SRAM contents NOT reset.
//  gnt_o is combinational: =1 whenever stall injection is off (see CONFIGURATION); gnt_o=0 while rst_ni=0.
//  Index = (addr_i-BASE_ADDR) >> log2(STRB); in range iff addr_i>=BASE_ADDR and index<NUM_WORDS (64-bit compare, no wrap).
//  Low log2(STRB) address bits ignored (aligned word access only).
//  Handshake cycle N: in-range write updates bytes with strb_i=1 at edge N; in-range read samples array.
//  Cycle N+1: rvalid_o=1, err_o=!in_range; rdata_o=array word (read), ERR_DATA (OOR read), 0 (any write).
//  OOR writes are dropped. Back-to-back handshakes allowed every cycle; throughput 1/cycle, no queuing.
//  Read after write, same index, consecutive cycles: read returns the newly written data (array written before read).
//  Same-cycle read/write impossible (single port). strb_i=0 write: no array change, still counted, still rvalid.
//  Counters increment once per handshake, saturate at all-ones (no wrap).
//  Reset mid-operation: pending response is discarded (rvalid_o=0 next cycle); array keeps the completed writes.
// CONFIGURATION
//  Macro MEM_SRAM_BRIDGE_STALL_INJECT_EN:
//   defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle out of reset;
//            gnt_o = req_i-independent !(lfsr[1:0]==2'b00), i.e. ~25% grant-withheld cycles; held request must stay stable.
//   undefined: LFSR absent, gnt_o=1 constantly out of reset.
// STRUCTURE
//  Package mem_bridge_pkg: addr_t, data_t, strb_t typedefs, LFSR_SEED, LFSR_TAPS constants.
//  Sub-module mem_bridge_sram: 1RW byte-enabled synchronous array, 1-cycle read, no reset.
//  Top: range check, handshake, response regs, counters, optional LFSR.
// TESTING
//  1. Reset, write 0x1122334455667788 strb FF @0x8000_0000, read same -> rvalid next cycle, data matches, err=0.
//  2. Write strb 0x0F data all-ones @0x8000_0008 over 0 -> read returns 0x00000000FFFFFFFF.
//  3. Read 0x7FFF_FFF8 and 0x8000_0000+NUM_WORDS*8 -> err_o=1, rdata=ERR_DATA; err_cnt=2; OOR write leaves array unchanged.
//  4. Write then read same addr in consecutive cycles, 100 back-to-back random ops -> scoreboard match, rd/wr counts exact.
//  5. Assert rst_ni=0 in cycle after read handshake -> rvalid_o=0 next cycle, counters 0, prior written data still readable.
//  6. With MEM_SRAM_BRIDGE_STALL_INJECT_EN: 1000 cycles req_i=1 -> gnt_o low on LFSR[1:0]==0 cycles, no lost/duplicate responses.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the SRAM-backed req/gnt memory bridge.
package mem_bridge_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;
  typedef logic [15:0] lfsr_t;

  localparam lfsr_t LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0].
  localparam lfsr_t LFSR_TAPS = 16'hB400;

  localparam logic [1:0] RESP_ZERO = 2'd0;
  localparam logic [1:0] RESP_MEM  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  function automatic lfsr_t lfsr_next(input lfsr_t state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_bridge_sram.sv
// Single-port byte-enabled synchronous SRAM, 1-cycle read latency, contents not reset.
module mem_bridge_sram #(
  parameter int NUM_WORDS  = 1024,
  parameter int DATA_WIDTH = 64,
  parameter int IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    en_i,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (strb_i[b]) mem[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (en_i && !we_i) rdata_o <= mem[idx_i];
  end

endmodule

// File: rtl/mem_sram_bridge.sv
// req/gnt memory port backed by on-chip SRAM with range check, response regs and counters.
// Optional grant-stall injection via macro MEM_SRAM_BRIDGE_STALL_INJECT_EN.
module mem_sram_bridge
  import mem_bridge_pkg::*;
#(
  parameter int                    NUM_WORDS  = 1024,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h8000_0000,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 64'hDEAD_BEEF_DEAD_BEEF,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic [CNT_WIDTH-1:0]    rd_cnt_o,
  output logic [CNT_WIDTH-1:0]    wr_cnt_o,
  output logic [CNT_WIDTH-1:0]    err_cnt_o
);

  localparam int STRB  = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(STRB);
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(NUM_WORDS);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  hs;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic [1:0]            resp_sel;

  // Addresses below the base are rejected explicitly so the subtraction never wraps into range.
  assign offset   = addr_i - BASE_ADDR;
  assign word_idx = offset >> SHIFT;
  assign in_range = (addr_i >= BASE_ADDR) && (word_idx < DEPTH);

`ifdef MEM_SRAM_BRIDGE_STALL_INJECT_EN
  lfsr_t lfsr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) lfsr <= LFSR_SEED;
    else         lfsr <= lfsr_next(lfsr);
  end

  assign gnt_o = rst_ni & (lfsr[1:0] != 2'b00);
`else
  assign gnt_o = rst_ni;
`endif

  assign hs = req_i & gnt_o;

  mem_bridge_sram #(
    .NUM_WORDS  (NUM_WORDS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (hs & in_range),
    .we_i    (we_i),
    .idx_i   (word_idx[IDX_W-1:0]),
    .strb_i  (strb_i),
    .wdata_i (wdata_i),
    .rdata_o (sram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      resp_sel <= RESP_ZERO;
    end else begin
      rvalid_o <= hs;
      err_o    <= hs & !in_range;
      if (hs && !we_i) resp_sel <= in_range ? RESP_MEM : RESP_ERR;
      else             resp_sel <= RESP_ZERO;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (resp_sel)
      RESP_MEM: rdata_o = sram_rdata;
      RESP_ERR: rdata_o = ERR_DATA;
      default:  rdata_o = '0;
    endcase
  end

  // Counters saturate at all-ones so long fuzzing runs never wrap back to small values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt_o  <= '0;
      wr_cnt_o  <= '0;
      err_cnt_o <= '0;
    end else if (hs) begin
      if (!in_range) begin
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
      end else if (we_i) begin
        if (wr_cnt_o != '1) wr_cnt_o <= wr_cnt_o + CNT_WIDTH'(1);
      end else begin
        if (rd_cnt_o != '1) rd_cnt_o <= rd_cnt_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule
